// File: rtl/mem_cmd_arbiter_if.sv
// Requester and memory-bus signal bundle for the round-robin memory command arbiter.
// The arbiter uses the slave modport; requesters and the memory model use the master side.
interface mem_cmd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rd_data;
  logic               busy;
  logic [2:0]         cmd;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, done, rd_data, busy, cmd, mem_addr, mem_wdata
  );

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, done, rd_data, busy, cmd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_cmd_arbiter.sv
// Round-robin arbiter sequencing one two-phase write/read command at a time on a shared memory bus.
// Latency: gnt + first command 1 cycle after IDLE sample, done 3 cycles after; requests wait while busy.
module mem_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 8,
  parameter int DW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  mem_cmd_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_WR1 = 3'b011;
  localparam logic [2:0] CMD_WR2 = 3'b101;
  localparam logic [2:0] CMD_RD1 = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_WR1, S_WR2, S_RD1, S_RD2} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [2:0]      r_cmd;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_busy;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW-1:0]   r_rd_data;

  state_t          w_state_nxt;
  logic            w_any;
  logic            w_accept;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_cand;
  logic [IW-1:0]   w_idx_nxt;
  logic [2:0]      w_cmd_nxt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [NREQ-1:0] w_done_nxt;

  always_comb begin
    w_any       = |bus.req;
    w_sel       = r_ptr;
    w_cand      = '0;
    w_state_nxt = r_state;
    w_cmd_nxt   = CMD_NOP;
    // Walk from farthest to nearest so the first set bit after ptr wins.
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(r_ptr) + k) % NREQ);
      if (bus.req[w_cand]) w_sel = w_cand;
    end
    w_accept = (r_state == S_IDLE) && w_any;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = bus.req_we[w_sel] ? S_WR1 : S_RD1;
      S_WR1:   w_state_nxt = S_WR2;
      S_WR2:   w_state_nxt = S_IDLE;
      S_RD1:   w_state_nxt = S_RD2;
      S_RD2:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_WR1:   w_cmd_nxt = CMD_WR1;
      S_WR2:   w_cmd_nxt = CMD_WR2;
      S_RD1:   w_cmd_nxt = CMD_RD1;
      default: w_cmd_nxt = CMD_NOP;
    endcase
    w_idx_nxt  = w_accept ? w_sel : r_idx;
    w_gnt_nxt  = ((w_state_nxt == S_WR1) || (w_state_nxt == S_RD1)) ?
                 (NREQ'(1) << w_idx_nxt) : '0;
    w_done_nxt = ((r_state == S_WR2) || (r_state == S_RD2)) ?
                 (NREQ'(1) << r_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= IW'(NREQ - 1);
      r_idx       <= '0;
      r_cmd       <= CMD_NOP;
      r_gnt       <= '0;
      r_done      <= '0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cmd   <= w_cmd_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_idx      <= w_sel;
        r_ptr      <= w_sel;
        r_mem_addr <= bus.req_addr[w_sel*AW +: AW];
        if (bus.req_we[w_sel]) r_mem_wdata <= bus.req_wdata[w_sel*DW +: DW];
      end
      if (r_state == S_RD2) r_rd_data <= bus.mem_rdata;
    end
  end

  assign bus.cmd       = r_cmd;
  assign bus.gnt       = r_gnt;
  assign bus.done      = r_done;
  assign bus.busy      = r_busy;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rd_data   = r_rd_data;
endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Directed bench for mem_cmd_arbiter: reset, single write/read, rotation, reset mid-read, round robin.
module tb_mem_cmd_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  mem_cmd_arbiter_if #(.NREQ(4), .AW(8), .DW(8)) bus ();

  mem_cmd_arbiter #(.NREQ(4), .AW(8), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_gnt;
  logic [3:0] exp_done;

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_rdata = '0;

    // Reset held two cycles
    tick();
    tick();
    chk("rst_cmd",   32'(bus.cmd),       32'h7);
    chk("rst_gnt",   32'(bus.gnt),       32'h0);
    chk("rst_done",  32'(bus.done),      32'h0);
    chk("rst_busy",  32'(bus.busy),      32'h0);
    chk("rst_addr",  32'(bus.mem_addr),  32'h0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'h0);
    chk("rst_rdata", 32'(bus.rd_data),   32'h0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle", 32'({bus.cmd, bus.gnt, bus.done, bus.busy}), 32'({3'b111, 4'b0, 4'b0, 1'b0}));
    end

    // Single write from requester 2
    bus.req_we[2]          = 1'b1;
    bus.req_addr[16 +: 8]  = 8'h3C;
    bus.req_wdata[16 +: 8] = 8'hA5;
    bus.req                = 4'b0100;
    tick();
    chk("wr_cmd1",  32'(bus.cmd),       32'h3);
    chk("wr_gnt",   32'(bus.gnt),       32'h4);
    chk("wr_addr",  32'(bus.mem_addr),  32'h3C);
    chk("wr_wdata", 32'(bus.mem_wdata), 32'hA5);
    chk("wr_busy",  32'(bus.busy),      32'h1);
    bus.req = 4'b0000;
    tick();
    chk("wr_cmd2",  32'(bus.cmd),       32'h5);
    chk("wr_gnt0",  32'(bus.gnt),       32'h0);
    chk("wr_hold",  32'({bus.mem_addr, bus.mem_wdata}), 32'h3CA5);
    tick();
    chk("wr_cmd3",  32'(bus.cmd),       32'h7);
    chk("wr_done",  32'(bus.done),      32'h4);
    chk("wr_busy0", 32'(bus.busy),      32'h0);
    chk("wr_rdata", 32'(bus.rd_data),   32'h0);
    tick();
    chk("wr_done0", 32'(bus.done),      32'h0);

    // Single read from requester 1
    bus.mem_rdata        = 8'h5A;
    bus.req_we[1]        = 1'b0;
    bus.req_addr[8 +: 8] = 8'h10;
    bus.req              = 4'b0010;
    tick();
    chk("rd_cmd1", 32'(bus.cmd),      32'h6);
    chk("rd_gnt",  32'(bus.gnt),      32'h2);
    chk("rd_addr", 32'(bus.mem_addr), 32'h10);
    bus.req = 4'b0000;
    tick();
    chk("rd_cmd2", 32'({bus.cmd, bus.busy, bus.done}), 32'({3'b111, 1'b1, 4'b0}));
    tick();
    chk("rd_done",  32'(bus.done),    32'h2);
    chk("rd_data",  32'(bus.rd_data), 32'h5A);
    chk("rd_wdata", 32'(bus.mem_wdata), 32'hA5);

    // Rotation: ptr=1, requesters 0 and 3 together -> 3 first
    bus.mem_rdata         = 8'h77;
    bus.req_we            = 4'b0000;
    bus.req_addr[0 +: 8]  = 8'h01;
    bus.req_addr[24 +: 8] = 8'h33;
    bus.req               = 4'b1001;
    tick();
    chk("rot_gnt3",  32'(bus.gnt),      32'h8);
    chk("rot_addr3", 32'(bus.mem_addr), 32'h33);
    bus.req = 4'b0001;
    tick();
    tick();
    chk("rot_done3", 32'(bus.done),    32'h8);
    chk("rot_data3", 32'(bus.rd_data), 32'h77);
    tick();
    chk("rot_gnt0",  32'(bus.gnt),      32'h1);
    chk("rot_addr0", 32'(bus.mem_addr), 32'h01);
    bus.req       = 4'b0000;
    bus.mem_rdata = 8'h66;
    tick();
    tick();
    chk("rot_done0", 32'(bus.done),    32'h1);
    chk("rot_data0", 32'(bus.rd_data), 32'h66);

    // Reset during RD_S2 abandons the read
    bus.mem_rdata        = 8'h99;
    bus.req_addr[8 +: 8] = 8'h20;
    bus.req              = 4'b0010;
    tick();
    chk("mr_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick();
    chk("mr_rds2", 32'({bus.cmd, bus.busy}), 32'({3'b111, 1'b1}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_cmd",   32'(bus.cmd),     32'h7);
    chk("mr_done",  32'(bus.done),    32'h0);
    chk("mr_rdata", 32'(bus.rd_data), 32'h0);
    chk("mr_busy",  32'(bus.busy),    32'h0);
    tick();
    chk("mr_done1", 32'(bus.done),    32'h0);
    bus.req = 4'b0011;
    tick();
    chk("mr_gnt0", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0010;
    tick();
    tick();
    chk("mr_done0", 32'(bus.done), 32'h1);
    tick();
    chk("mr_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick();
    tick();
    chk("mr_done1b", 32'(bus.done), 32'h2);

    // Round robin from reset with all four writing
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_we = 4'b1111;
    bus.req    = 4'b1111;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp_gnt  = (c == 1) ? 4'b0001 : (c == 4) ? 4'b0010 : (c == 7) ? 4'b0100 :
                 (c == 10) ? 4'b1000 : (c == 13) ? 4'b0001 : 4'b0000;
      exp_done = (c == 3) ? 4'b0001 : (c == 6) ? 4'b0010 : (c == 9) ? 4'b0100 :
                 (c == 12) ? 4'b1000 : (c == 15) ? 4'b0001 : 4'b0000;
      chk($sformatf("rr_c%0d", c), 32'({bus.gnt, bus.done}), 32'({exp_gnt, exp_done}));
      if (c == 2)  bus.req[0] = 1'b0;
      if (c == 5)  bus.req[1] = 1'b0;
      if (c == 8)  bus.req[2] = 1'b0;
      if (c == 11) begin
        bus.req[3] = 1'b0;
        bus.req[0] = 1'b1;
      end
      if (c == 14) bus.req[0] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
